turfio_cin_autotrain: RTL
=========================

Name: turfio_cin_autotrain

Overview:
- Wishbone-clock sequencer that automates CIN link training on the SURF side of the TURFIO link.
- Sweeps the CIN IDELAY tap and measures bit errors at each tap. Finds the widest error-free eye and loads its centre.
- Then steps bitslip until the CIN parallelizer reports lock.
- Drives the same delay/VTC/bitslip/lock controls that software otherwise drives by hand. Those controls are muxed by the register core when autotrain is enabled.

Parameters:
- TAP_W, 9: IDELAY count width.
- TAP_STEP, 8: tap increment per sweep point (power of 2).
- SETTLE, 16: cycles waited after each delay load or VTC change.
- DWELL, 1024: error-observation cycles per sweep point.
- MIN_EYE, 4: minimum accepted eye, in sweep points.
- NSLIP, 8: bitslip positions tried before failing.
- LOCK_WAIT, 256: cycles to wait for lock_status_i after each lock request.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle start pulse; ignored while busy_o=1.
- abort_i  in  1  single-cycle abort pulse.
- cin_err_i  in  1  CIN bit error, already synchronized to wb_clk_i, level.
- lock_status_i  in  1  parallelizer locked, already synchronized.
- busy_o  out  1  sequence running.
- done_o  out  1  sticky success, cleared on start.
- fail_o  out  1  sticky failure, cleared on start.
- fail_code_o  out  2  0 none, 1 no eye, 2 no lock, 3 aborted.
- en_vtc_o  out  1  IDELAY VTC enable.
- delay_load_o  out  1  one-cycle load strobe.
- delay_cntvaluein_o  out  TAP_W  tap value presented with the load.
- bitslip_rst_o  out  1  one-cycle pulse.
- bitslip_o  out  1  one-cycle pulse.
- lock_req_o  out  1  one-cycle pulse.
- eye_start_o  out  TAP_W  first tap of the chosen eye.
- eye_len_o  out  TAP_W  chosen eye length in sweep points.
- slip_cnt_o  out  4  bitslips applied.

Behaviour:
- Reset values:
  - en_vtc_o=1.
  - All other outputs 0.
  - State IDLE.
- States: IDLE, VTC_OFF, LOAD, SETTLE, DWELL, EVAL, CENTER, CSETTLE, VTC_ON, SLIP_RST, LOCK_REQ, LOCK_WAIT, SLIP, DONE, FAIL.
- IDLE:
  - start_i → clear done/fail/fail_code/eye/slip_cnt.
  - tap=0, run registers=0.
  - Go to VTC_OFF; busy_o=1 from the next cycle.
- VTC_OFF: en_vtc_o=0, wait SETTLE cycles → LOAD.
- LOAD: delay_load_o=1 for exactly one cycle, with delay_cntvaluein_o=tap on that same cycle → SETTLE (SETTLE cycles) → DWELL.
- DWELL:
  - For DWELL cycles, err_seen |= cin_err_i.
  - cin_err_i during SETTLE is ignored.
- EVAL, if err_seen=0:
  - If run_len=0, set run_start=tap.
  - run_len++.
- EVAL, if err_seen=1: close the run.
- Closing a run: if run_len > best_len (strictly greater; the lowest-tap eye wins ties), best ← run; then run_len=0.
- EVAL, next step:
  - If tap+TAP_STEP ≤ 2^TAP_W−1: tap += TAP_STEP → LOAD.
  - Otherwise close any open run (the last tap counts; no wrap-around joining with tap 0) → CENTER.
- CENTER:
  - If best_len < MIN_EYE → FAIL, code 1.
  - Otherwise tap = best_start + (((best_len−1)·TAP_STEP)>>1), computed in TAP_W+4 bits; the result is guaranteed ≤ max tap.
  - Issue one delay_load_o → CSETTLE (SETTLE) → VTC_ON.
- VTC_ON:
  - en_vtc_o=1.
  - eye_start_o/eye_len_o updated.
  - → SLIP_RST.
- SLIP_RST: bitslip_rst_o pulse, slip_cnt=0 → LOCK_REQ.
- LOCK_REQ: lock_req_o pulse → LOCK_WAIT.
- LOCK_WAIT:
  - lock_status_i=1 within LOCK_WAIT cycles → DONE.
  - Timeout with slip_cnt < NSLIP−1 → SLIP.
  - Timeout otherwise → FAIL, code 2.
- SLIP: bitslip_o pulse, slip_cnt++ → LOCK_REQ.
- DONE: done_o=1, busy_o=0 → IDLE.
- FAIL: fail_o=1, busy_o=0, en_vtc_o=1 → IDLE.
- abort_i while busy:
  - Next cycle en_vtc_o=1, fail_o=1, code 3, busy_o=0, IDLE.
  - No further strobes are issued.
  - abort_i while idle is ignored.
  - If abort_i and start_i arrive together in IDLE, start wins.
- Asynchronous reset mid-sequence returns to reset values immediately; no strobe is completed.
- Strobe spacing: delay_load_o, bitslip_o, bitslip_rst_o and lock_req_o are never asserted on the same cycle as each other, and each is a single cycle.

Test Plan:
- Errors forced for taps 0–63 and 200–511, clean for 64–199:
  - best run = 64..192, 17 points.
  - Centre = 64+((16·8)>>1)=128.
  - Final load value 128; done_o=1; slip_cnt_o=0 when lock is returned on the first request.
- Two clean windows of 5 points each (taps 40–72 and 300–332):
  - eye_start_o=40 (tie keeps the lowest).
  - Loaded tap 56.
- Errors at every tap: fail_o=1, fail_code_o=1, en_vtc_o=1, no bitslip or lock pulses.
- Clean eye, lock_status_i only asserted after 3 bitslips:
  - Exactly 3 bitslip_o pulses and 4 lock_req_o pulses; slip_cnt_o=3; done_o=1.
  - Same case with lock never asserted: 7 bitslips, then fail_code_o=2.
- Clean window 488–511, errors elsewhere:
  - Open run closed at the end of the sweep.
  - eye_start_o=488, eye_len_o=3, below MIN_EYE → fail_code_o=1.
  - Same window with MIN_EYE=3 → tap 496, done_o=1.
- Interrupts:
  - abort_i in DWELL of tap 80: next cycle busy_o=0, en_vtc_o=1, fail_code_o=3, no further delay_load_o.
  - wb_rst_n_i low mid-SLIP: all outputs at reset values asynchronously.
  - start_i while busy: no effect on state or counters.

Source files
------------

// File: rtl/turfio_cin_autotrain_if.sv
// Control/status bundle between the CIN autotrain sequencer and the register core / IDELAY.
interface turfio_cin_autotrain_if #(
    parameter int TAP_W = 9
);
    logic             start_i;
    logic             abort_i;
    logic             cin_err_i;
    logic             lock_status_i;
    logic             busy_o;
    logic             done_o;
    logic             fail_o;
    logic [1:0]       fail_code_o;
    logic             en_vtc_o;
    logic             delay_load_o;
    logic [TAP_W-1:0] delay_cntvaluein_o;
    logic             bitslip_rst_o;
    logic             bitslip_o;
    logic             lock_req_o;
    logic [TAP_W-1:0] eye_start_o;
    logic [TAP_W-1:0] eye_len_o;
    logic [3:0]       slip_cnt_o;

    modport master (
        input  start_i, abort_i, cin_err_i, lock_status_i,
        output busy_o, done_o, fail_o, fail_code_o, en_vtc_o, delay_load_o,
               delay_cntvaluein_o, bitslip_rst_o, bitslip_o, lock_req_o,
               eye_start_o, eye_len_o, slip_cnt_o
    );

    modport slave (
        output start_i, abort_i, cin_err_i, lock_status_i,
        input  busy_o, done_o, fail_o, fail_code_o, en_vtc_o, delay_load_o,
               delay_cntvaluein_o, bitslip_rst_o, bitslip_o, lock_req_o,
               eye_start_o, eye_len_o, slip_cnt_o
    );
endinterface

// File: rtl/turfio_cin_autotrain.sv
// CIN link autotrain: IDELAY eye sweep, centre load, then bitslip until the parallelizer locks.
module turfio_cin_autotrain #(
    parameter int TAP_W     = 9,
    parameter int TAP_STEP  = 8,
    parameter int SETTLE    = 16,
    parameter int DWELL     = 1024,
    parameter int MIN_EYE   = 4,
    parameter int NSLIP     = 8,
    parameter int LOCK_WAIT = 256
) (
    input logic wb_clk_i,
    input logic wb_rst_n_i,
    turfio_cin_autotrain_if.master bus
);
    localparam int TMR_A   = (DWELL > LOCK_WAIT) ? DWELL : LOCK_WAIT;
    localparam int TMR_TOP = (TMR_A > SETTLE) ? TMR_A : SETTLE;
    localparam int TMR_W   = $clog2(TMR_TOP + 1);
    localparam int STEP_SH = $clog2(TAP_STEP);

    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] DWELL_LD  = TMR_W'(DWELL - 1);
    localparam logic [TMR_W-1:0] LOCK_LD   = TMR_W'(LOCK_WAIT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [TAP_W:0]   MAX_TAP   = {1'b0, {TAP_W{1'b1}}};
    localparam logic [TAP_W:0]   STEP_X    = (TAP_W + 1)'(TAP_STEP);
    localparam logic [TAP_W-1:0] ONE_T     = TAP_W'(1);
    localparam logic [TAP_W+3:0] ONE_X     = (TAP_W + 4)'(1);
    localparam logic [TAP_W-1:0] MIN_EYE_X = TAP_W'(MIN_EYE);
    localparam logic [3:0]       SLIP_LAST = 4'(NSLIP - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_VTC_OFF, S_LOAD, S_SETTLE, S_DWELL, S_EVAL, S_CENTER, S_CSETTLE,
        S_VTC_ON, S_SLIP_RST, S_LOCK_REQ, S_LOCK_WAIT, S_SLIP, S_DONE, S_FAIL
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [TAP_W-1:0] tap, run_start, run_len, best_start, best_len;
    logic             err_seen;

    logic [TAP_W:0]   tap_next;
    logic             last_pt;
    logic [TAP_W-1:0] cand_len, cand_start;
    logic [TAP_W+3:0] center_x;
    logic             center_ok;

    always_comb begin
        tap_next   = {1'b0, tap} + STEP_X;
        last_pt    = tap_next > MAX_TAP;
        cand_len   = err_seen ? run_len : run_len + ONE_T;
        cand_start = (run_len == '0) ? tap : run_start;
        center_x   = {4'b0, best_start} + ((({4'b0, best_len} - ONE_X) << STEP_SH) >> 1);
        center_ok  = (center_x[TAP_W+3:TAP_W] == 4'b0);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state                  <= S_IDLE;
            timer                  <= '0;
            tap                    <= '0;
            run_start              <= '0;
            run_len                <= '0;
            best_start             <= '0;
            best_len               <= '0;
            err_seen               <= 1'b0;
            bus.busy_o             <= 1'b0;
            bus.done_o             <= 1'b0;
            bus.fail_o             <= 1'b0;
            bus.fail_code_o        <= 2'd0;
            bus.en_vtc_o           <= 1'b1;
            bus.delay_load_o       <= 1'b0;
            bus.delay_cntvaluein_o <= '0;
            bus.bitslip_rst_o      <= 1'b0;
            bus.bitslip_o          <= 1'b0;
            bus.lock_req_o         <= 1'b0;
            bus.eye_start_o        <= '0;
            bus.eye_len_o          <= '0;
            bus.slip_cnt_o         <= 4'd0;
        end else begin
            bus.delay_load_o  <= 1'b0;
            bus.bitslip_rst_o <= 1'b0;
            bus.bitslip_o     <= 1'b0;
            bus.lock_req_o    <= 1'b0;
            if (bus.abort_i && bus.busy_o) begin
                state           <= S_IDLE;
                bus.busy_o      <= 1'b0;
                bus.fail_o      <= 1'b1;
                bus.fail_code_o <= 2'd3;
                bus.en_vtc_o    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (bus.start_i) begin
                        bus.done_o      <= 1'b0;
                        bus.fail_o      <= 1'b0;
                        bus.fail_code_o <= 2'd0;
                        bus.eye_start_o <= '0;
                        bus.eye_len_o   <= '0;
                        bus.slip_cnt_o  <= 4'd0;
                        bus.busy_o      <= 1'b1;
                        bus.en_vtc_o    <= 1'b0;
                        tap             <= '0;
                        run_start       <= '0;
                        run_len         <= '0;
                        best_start      <= '0;
                        best_len        <= '0;
                        timer           <= SETTLE_LD;
                        state           <= S_VTC_OFF;
                    end
                    S_VTC_OFF: if (timer == '0) begin
                        bus.delay_load_o       <= 1'b1;
                        bus.delay_cntvaluein_o <= tap;
                        state                  <= S_LOAD;
                    end else timer <= timer - TMR_ONE;
                    S_LOAD: begin
                        timer <= SETTLE_LD;
                        state <= S_SETTLE;
                    end
                    S_SETTLE: if (timer == '0) begin
                        err_seen <= 1'b0;
                        timer    <= DWELL_LD;
                        state    <= S_DWELL;
                    end else timer <= timer - TMR_ONE;
                    S_DWELL: begin
                        err_seen <= err_seen | bus.cin_err_i;
                        if (timer == '0) state <= S_EVAL;
                        else timer <= timer - TMR_ONE;
                    end
                    S_EVAL: begin
                        // A run closes on an error or at the sweep end; ties keep the earlier eye.
                        if (err_seen || last_pt) begin
                            run_len <= '0;
                            if (cand_len > best_len) begin
                                best_len   <= cand_len;
                                best_start <= cand_start;
                            end
                        end else begin
                            run_len   <= cand_len;
                            run_start <= cand_start;
                        end
                        if (last_pt) state <= S_CENTER;
                        else begin
                            tap                    <= tap_next[TAP_W-1:0];
                            bus.delay_load_o       <= 1'b1;
                            bus.delay_cntvaluein_o <= tap_next[TAP_W-1:0];
                            state                  <= S_LOAD;
                        end
                    end
                    S_CENTER: begin
                        bus.eye_start_o <= best_start;
                        bus.eye_len_o   <= best_len;
                        if (best_len < MIN_EYE_X || !center_ok) begin
                            bus.fail_o      <= 1'b1;
                            bus.fail_code_o <= 2'd1;
                            bus.busy_o      <= 1'b0;
                            bus.en_vtc_o    <= 1'b1;
                            state           <= S_FAIL;
                        end else begin
                            tap                    <= center_x[TAP_W-1:0];
                            bus.delay_load_o       <= 1'b1;
                            bus.delay_cntvaluein_o <= center_x[TAP_W-1:0];
                            timer                  <= SETTLE_LD;
                            state                  <= S_CSETTLE;
                        end
                    end
                    S_CSETTLE: if (timer == '0) begin
                        bus.en_vtc_o <= 1'b1;
                        state        <= S_VTC_ON;
                    end else timer <= timer - TMR_ONE;
                    S_VTC_ON: begin
                        bus.bitslip_rst_o <= 1'b1;
                        bus.slip_cnt_o    <= 4'd0;
                        state             <= S_SLIP_RST;
                    end
                    S_SLIP_RST: begin
                        bus.lock_req_o <= 1'b1;
                        state          <= S_LOCK_REQ;
                    end
                    S_LOCK_REQ: begin
                        timer <= LOCK_LD;
                        state <= S_LOCK_WAIT;
                    end
                    S_LOCK_WAIT: if (bus.lock_status_i) begin
                        bus.done_o <= 1'b1;
                        bus.busy_o <= 1'b0;
                        state      <= S_DONE;
                    end else if (timer == '0) begin
                        if (bus.slip_cnt_o < SLIP_LAST) begin
                            bus.bitslip_o <= 1'b1;
                            state         <= S_SLIP;
                        end else begin
                            bus.fail_o      <= 1'b1;
                            bus.fail_code_o <= 2'd2;
                            bus.busy_o      <= 1'b0;
                            bus.en_vtc_o    <= 1'b1;
                            state           <= S_FAIL;
                        end
                    end else timer <= timer - TMR_ONE;
                    S_SLIP: begin
                        bus.slip_cnt_o <= bus.slip_cnt_o + 4'd1;
                        bus.lock_req_o <= 1'b1;
                        state          <= S_LOCK_REQ;
                    end
                    S_DONE:  state <= S_IDLE;
                    S_FAIL:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
